// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared constants, scan state type and nibble check for the display scanner
package bcd_disp_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic       DIGIT_OFF = 1'b1;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic logic nibble_bad(input logic [3:0] nib);
        return nib > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_scan_timer.sv
// rtl/bcd_display_scanner_scan_timer.sv - slot counter and digit index for the display scan
module scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    localparam int CW = $clog2(REFRESH_DIV),
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] digit_idx,
    output logic [IW-1:0] next_idx,
    output logic          slot_wrap,
    output logic          frame_wrap,
    output logic          in_guard
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LEN = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] cnt_next;

    assign slot_wrap  = (slot_cnt == CNT_LAST);
    assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);
    assign cnt_next   = slot_wrap ? '0 : slot_cnt + CW'(1);
    assign next_idx   = !slot_wrap ? digit_idx :
                        (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);

    // Guard status of the cycle that follows this edge, so the caller can register outputs in step
    assign in_guard   = (cnt_next < GUARD_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt  <= cnt_next;
            digit_idx <= next_idx;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed 7-segment scan controller; LEADING_ZERO_BLANK_EN enables leading-zero blanking
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    blank,
    output logic                    frame_done,
    output logic                    bad_digit
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{DIGIT_OFF}};

    logic [IW-1:0] digit_idx;
    logic [IW-1:0] next_idx;
    logic          slot_wrap;
    logic          frame_wrap;
    logic          in_guard;

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_idx  (digit_idx),
        .next_idx   (next_idx),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap),
        .in_guard   (in_guard)
    );

    logic [NUM_DIGITS-1:0][3:0] cur_val;
    logic [NUM_DIGITS-1:0][3:0] pend_val;
    logic [NUM_DIGITS-1:0][3:0] nxt_val;
    logic                       pend_valid;
    logic                       nxt_bad;

    // A load in the boundary cycle itself bypasses the pending register
    always_comb begin
        nxt_val = cur_val;
        if (frame_wrap) begin
            if (load)
                nxt_val = value_in;
            else if (pend_valid)
                nxt_val = pend_val;
        end
    end

    always_comb begin
        nxt_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (nibble_bad(nxt_val[i]))
                nxt_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_val    <= '0;
            pend_val   <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (load)
                pend_val <= value_in;
            if (frame_wrap) begin
                cur_val    <= nxt_val;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    logic lz_hide;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] nxt_lz;

    // Bit i set when digit i and every digit above it are zero; digit 0 always shows
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        nxt_lz     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (nxt_val[i] == 4'd0);
            nxt_lz[i]  = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lz_mask <= '0;
        else if (frame_wrap)
            lz_mask <= nxt_lz;
    end

    assign lz_hide = lz_mask[digit_idx];
`else
    assign lz_hide = 1'b0;
`endif

    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic                  blank_nxt;
    logic [3:0]            bcd_nxt;
    logic                  hide;

    assign hide = nibble_bad(cur_val[digit_idx]) || lz_hide;

    always_comb begin
        state_nxt = state;
        sel_nxt   = digit_sel;
        blank_nxt = blank;
        bcd_nxt   = digit_bcd;
        case (state)
            GUARD: begin
                if (!in_guard) begin
                    state_nxt = SHOW;
                    sel_nxt   = ALL_OFF;
                    if (!hide) begin
                        sel_nxt[digit_idx] = ~DIGIT_OFF;
                        blank_nxt          = 1'b0;
                    end
                end
            end
            SHOW: begin
                if (slot_wrap) begin
                    state_nxt = GUARD;
                    sel_nxt   = ALL_OFF;
                    blank_nxt = 1'b1;
                    bcd_nxt   = nxt_val[next_idx];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GUARD;
            digit_bcd  <= 4'd0;
            digit_sel  <= ALL_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            bad_digit  <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit_bcd  <= bcd_nxt;
            digit_sel  <= sel_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_wrap;
            if (frame_wrap)
                bad_digit <= nxt_bad;
        end
    end

endmodule
